// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shared framebuffer port arbiter with upscaled scan-out; FBARB_STALL_CNT_EN adds stall_cnt
module vga_fb_arbiter #(
    parameter int         FB_W        = 160,
    parameter int         FB_H        = 120,
    parameter int         SCALE_SHIFT = 2,
    parameter int         ADDR_W      = 15,
    parameter logic [2:0] BORDER_RGB  = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [2:0]        rgb,
    output logic              hsync,
    output logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    input  logic              clear_req,
    input  logic [2:0]        clear_color,
    output logic              clear_busy,
`ifdef FBARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [2:0]        ram_wdata,
    input  logic [2:0]        ram_rdata
);

    localparam int                AW2       = ADDR_W + SCALE_SHIFT;
    localparam logic [9:0]        LOW_MASK  = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0]        FB_W_L    = 10'(FB_W);
    localparam logic [9:0]        FB_H_L    = 10'(FB_H);
    localparam logic [ADDR_W:0]   FB_SIZE   = (ADDR_W + 1)'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [2:0]        r_clr_color;
    logic              r_vo_d1;
    logic              r_in_fb_d1;
    logic              r_rd_d1;
    logic              r_hs_d1;
    logic              r_vs_d1;

    logic [9:0]        w_fx;
    logic [9:0]        w_fy;
    logic              w_in_fb;
    logic              w_disp_rd;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_wr_in_range;
    logic              w_wr_fire;

    // Screen position mapped onto the framebuffer grid; one read per fb pixel column.
    assign w_fx      = pixel_x >> SCALE_SHIFT;
    assign w_fy      = pixel_y >> SCALE_SHIFT;
    assign w_in_fb   = video_on && (w_fx < FB_W_L) && (w_fy < FB_H_L);
    assign w_disp_rd = w_in_fb && ((pixel_x & LOW_MASK) == 10'd0);
    assign w_rd_addr = ADDR_W'(AW2'(w_fy) * AW2'(FB_W) + AW2'(w_fx));

    // Writer only gets the port when neither scan-out nor a fill wants it.
    assign wr_ready      = !w_disp_rd && !clear_busy && !rst;
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = {1'b0, wr_addr} < FB_SIZE;

    // Single RAM port mux: display read beats fill write beats external writer.
    always_comb begin
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        ram_we    = 1'b0;
        if (w_disp_rd) begin
            ram_addr = w_rd_addr;
        end else if (r_state == ST_CLEAR) begin
            ram_addr  = r_clr_addr;
            ram_wdata = r_clr_color;
            ram_we    = !rst;
        end else begin
            ram_we = w_wr_fire && w_wr_in_range;
        end
    end

    // Fill sequencer: walks every fb address, yielding to display reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            clear_busy  <= 1'b0;
            r_clr_addr  <= '0;
            r_clr_color <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_clr_color <= clear_color;
                        r_clr_addr  <= '0;
                        clear_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!w_disp_rd) begin
                        if (r_clr_addr == LAST_ADDR) begin
                            r_state    <= ST_IDLE;
                            clear_busy <= 1'b0;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // First pipeline stage: remember what kind of pixel was presented while RAM reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vo_d1    <= 1'b0;
            r_in_fb_d1 <= 1'b0;
            r_rd_d1    <= 1'b0;
            r_hs_d1    <= 1'b0;
            r_vs_d1    <= 1'b0;
        end else begin
            r_vo_d1    <= video_on;
            r_in_fb_d1 <= w_in_fb;
            r_rd_d1    <= w_disp_rd;
            r_hs_d1    <= hsync_in;
            r_vs_d1    <= vsync_in;
        end
    end

    // Second stage: pick colour; holding rgb between reads replicates pixels horizontally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb   <= 3'b000;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            hsync <= r_hs_d1;
            vsync <= r_vs_d1;
            if (!r_vo_d1) begin
                rgb <= 3'b000;
            end else if (!r_in_fb_d1) begin
                rgb <= BORDER_RGB;
            end else if (r_rd_d1) begin
                rgb <= ram_rdata;
            end
        end
    end

`ifdef FBARB_STALL_CNT_EN
    // Saturating count of cycles the writer waited; a new fill restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if ((r_state == ST_IDLE) && clear_req) begin
            stall_cnt <= 16'h0000;
        end else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized self-checking bench for vga_fb_arbiter
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    localparam int         FB_W   = 160;
    localparam int         FB_H   = 120;
    localparam int         S      = 2;
    localparam int         AW     = 15;
    localparam int         SIZE   = FB_W * FB_H;
    localparam logic [2:0] BORDER = 3'b110;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [9:0]    px = '0, py = '0;
    logic          vo = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic          wv = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [2:0]    wd = '0;
    logic          creq = 1'b0;
    logic [2:0]    ccol = '0;

    logic [2:0]    rgb;
    logic          hsync, vsync, wr_ready, clear_busy, ram_we;
    logic [AW-1:0] ram_addr;
    logic [2:0]    ram_wdata;
    logic [2:0]    ram_rdata;
`ifdef FBARB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(S), .ADDR_W(AW), .BORDER_RGB(BORDER)) dut (
        .clk(clk), .rst(rst), .pixel_x(px), .pixel_y(py), .video_on(vo),
        .hsync_in(hs_i), .vsync_in(vs_i), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .wr_valid(wv), .wr_ready(wr_ready), .wr_addr(wa), .wr_data(wd),
        .clear_req(creq), .clear_color(ccol), .clear_busy(clear_busy),
`ifdef FBARB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous read, one port
    logic [2:0] ram [0:32767];
    logic       ram_clr = 1'b0;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 3'b000;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [2:0] ref_fb [0:SIZE-1];
    bit         ref_inited = 0;
    logic [2:0] m_rgb = 0, m_s1 = 0, blk_val = 0, m_col = 0;
    bit         m_h1 = 0, m_h2 = 0, m_v1 = 0, m_v2 = 0, m_busy = 0, m_xfer = 0;
    int         m_clr = 0;
    int         we5_cnt = 0, we_total = 0, hs_oor = 0, busy_cyc = 0, busy_disp = 0;

    int         c_fx, c_fy, c_a, c_ea;
    bit         c_infb, c_disp, c_rdy, c_we;
    logic [2:0] c_tv, c_ewd;

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        if (rst) begin
            if (!ref_inited) begin
                for (int i = 0; i < SIZE; i++) ref_fb[i] = 3'b000;
                ref_inited = 1;
            end
            m_rgb = 0; m_s1 = 0; blk_val = 0;
            m_h1 = 0; m_h2 = 0; m_v1 = 0; m_v2 = 0;
            m_busy = 0; m_clr = 0;
        end
        c_fx   = int'(px) / (1 << S);
        c_fy   = int'(py) / (1 << S);
        c_infb = vo && (c_fx < FB_W) && (c_fy < FB_H);
        c_disp = c_infb && (int'(px) % (1 << S) == 0);
        c_a    = c_fy * FB_W + c_fx;
        c_rdy  = !c_disp && !m_busy && !rst;
        c_we   = 0; c_ea = 0; c_ewd = 0;
        if (!rst && !c_disp) begin
            if (m_busy) begin
                c_we = 1; c_ea = m_clr; c_ewd = m_col;
            end else if (wv && c_rdy && int'(wa) < SIZE) begin
                c_we = 1; c_ea = int'(wa); c_ewd = wd;
            end
        end
        if (!vo) c_tv = 3'b000;
        else if (!c_infb) c_tv = BORDER;
        else if (c_disp) begin
            c_tv = ref_fb[c_a];
            blk_val = c_tv;
        end else c_tv = blk_val;

        check("wr_ready", wr_ready, c_rdy);
        check("ram_we", ram_we, c_we);
        if (c_we) begin
            check("wr_addr_out", ram_addr, c_ea);
            check("wr_data_out", ram_wdata, c_ewd);
        end
        if (c_disp) check("rd_addr", ram_addr, c_a);
        check("rgb", rgb, m_rgb);
        check("hsync", hsync, m_h2);
        check("vsync", vsync, m_v2);
        check("clear_busy", clear_busy, m_busy);

        if (ram_we && ram_addr == 15'd5) we5_cnt++;
        if (ram_we) we_total++;
        if (wv && wr_ready && int'(wa) == SIZE) hs_oor++;
        if (clear_busy) begin
            busy_cyc++;
            if (c_disp) busy_disp++;
        end

        m_xfer = wv && c_rdy;
        if (!rst) begin
            if (c_we) ref_fb[c_ea] = c_ewd;
            if (m_busy) begin
                if (!c_disp) begin
                    if (m_clr == SIZE - 1) m_busy = 0;
                    else m_clr++;
                end
            end else if (creq) begin
                m_busy = 1; m_clr = 0; m_col = ccol;
            end
            m_rgb = m_s1; m_s1 = c_tv;
            m_h2 = m_h1; m_h1 = hs_i;
            m_v2 = m_v1; m_v1 = vs_i;
        end
    end

    bit rand_wr = 0;

    task automatic new_req();
        wv = 1'b1;
        if ($urandom_range(0, 19) == 0) wa = AW'(SIZE + $urandom_range(0, 100));
        else wa = AW'($urandom_range(0, SIZE - 1));
        wd = 3'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_xfer) begin
            if (rand_wr) new_req();
            else wv = 1'b0;
        end else if (rand_wr && !wv && $urandom_range(0, 3) == 0) begin
            new_req();
        end
    endtask

    task automatic write_px(input int a, input logic [2:0] d);
        vo = 1'b0; wv = 1'b1; wa = AW'(a); wd = d;
        for (int i = 0; i < 50 && wv; i++) tick();
        if (wv) begin
            check("write_timeout", 0, 1);
            wv = 1'b0;
        end
    endtask

    task automatic hold3(input int x, input int y, input bit v, input int exp, input string nm);
        px = 10'(x); py = 10'(y); vo = v; hs_i = 0; vs_i = 0;
        repeat (2) tick();
        @(negedge clk);
        check(nm, rgb, exp);
        tick();
    endtask

    int base_a, base_b, bad, cnt, x, y, n, x0;
    bit v;

    initial begin
        #1;
        rst = 1'b1; ram_clr = 1'b1;
        px = 10'd100; py = 10'd50; vo = 1; hs_i = 1; vs_i = 1; wv = 1; wa = 0; wd = 3;
        repeat (2) @(posedge clk);
        #1; ram_clr = 1'b0;
        @(negedge clk);
        check("rst_rgb", rgb, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; wv = 0; vo = 0; hs_i = 0; vs_i = 0;
        tick();

        write_px(0, 3'b101);
        write_px(1, 3'b010);

        // Scan x=0..7 on row 0
        for (int k = 0; k < 10; k++) begin
            px = 10'(k); py = 0; vo = (k < 8); hs_i = (k == 0); vs_i = (k == 1);
            @(negedge clk);
            if (k >= 2) begin
                check("scan_rgb", rgb, (k - 2 < 4) ? 5 : 2);
                check("scan_hsync", hsync, (k == 2));
                check("scan_vsync", vsync, (k == 3));
            end
            tick();
        end

        hold3(640, 0, 1, BORDER, "border_rgb");
        hold3(0, 0, 0, 0, "video_off_rgb");
        hold3(4, 0, 1, 2, "fb1_rgb");

        // Writer during active video
        base_a = we5_cnt;
        wv = 1; wa = 15'd5; wd = 3'b111;
        for (int k = 0; k < 16; k++) begin
            px = 10'(k); py = 0; vo = 1;
            @(negedge clk);
            check("rdy_pattern", wr_ready, (k % 4) != 0);
            tick();
        end
        vo = 0; repeat (2) tick();
        check("wr5_once", we5_cnt - base_a, 1);
        hold3(20, 0, 1, 7, "readback5");

        // Out-of-range writer address
        base_a = hs_oor; base_b = we_total;
        vo = 0; wv = 1; wa = AW'(SIZE); wd = 3'b001;
        repeat (4) tick();
        check("oor_handshake", hs_oor - base_a, 1);
        check("oor_no_we", we_total - base_b, 0);

        // Full clear with raster running; second request mid-clear ignored
        base_a = busy_cyc; base_b = busy_disp;
        creq = 1; ccol = 3'b011;
        for (cnt = 0; cnt < 40000; cnt++) begin
            x = cnt % 800; y = (cnt / 800) % 525;
            px = 10'(x); py = 10'(y); vo = (x < 640) && (y < 480);
            hs_i = (x >= 656) && (x < 752); vs_i = (y == 490) || (y == 491);
            if (cnt == 1 || cnt == 3001) creq = 0;
            if (cnt == 3000) begin creq = 1; ccol = 3'b101; end
            @(negedge clk);
            if (cnt > 2 && !clear_busy) break;
            tick();
        end
        check("clear_timeout", cnt < 40000, 1);
        check("clear_cycles", busy_cyc - base_a, SIZE + (busy_disp - base_b));
        vo = 0; tick(); tick();
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (ram[i] != 3'b011) bad++;
        check("clear_fill_bad", bad, 0);

        // Reset mid-clear
        creq = 1; ccol = 3'b110; vo = 0;
        tick();
        creq = 0;
        repeat (500) tick();
        rst = 1;
        @(negedge clk);
        check("rst_mid_busy", clear_busy, 0);
        check("rst_mid_rdy", wr_ready, 0);
        tick();
        rst = 0;
        tick();
        check("partial_last", ram[499], 3'b110);
        check("partial_next", ram[500], 3'b011);

        // Randomized raster runs with a random writer
        rand_wr = 1;
        for (int r = 0; r < 150; r++) begin
            y = $urandom_range(0, 499);
            x0 = 4 * $urandom_range(0, 199);
            n = $urandom_range(4, 40);
            v = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < n; i++) begin
                px = 10'(x0 + i); py = 10'(y); vo = v;
                hs_i = 1'($urandom); vs_i = 1'($urandom);
                tick();
            end
        end
        rand_wr = 0; vo = 0;
        for (int i = 0; i < 100 && wv; i++) tick();
        check("drain_writer", wv, 0);
        wv = 0; tick(); tick();
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (ram[i] != ref_fb[i]) bad++;
        check("final_fb_bad", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port pixel framebuffer RAM between three users: display scan-out, a fill/clear sequencer, and an external pixel writer.
- Sits between the VGA timing controller (pixel_x/pixel_y/video_on/hsync/vsync) and the RGB/sync pins.
- Upscales a small framebuffer by 2^SCALE_SHIFT in both axes.
- Delays hsync/vsync to stay aligned with the fetched pixel.

Parameters:
- FB_W, 160: framebuffer width in pixels.
- FB_H, 120: framebuffer height in pixels.
- SCALE_SHIFT, 2: log2 of the screen-pixel to fb-pixel scale factor.
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- BORDER_RGB, 3'b000: colour driven when video is on but the position is outside the fb area.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- pixel_x  in  10  current column from the timing controller
- pixel_y  in  10  current row from the timing controller
- video_on  in  1  active-video flag
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- rgb  out  3  pixel colour, registered
- hsync  out  1  hsync_in delayed by 2 cycles
- vsync  out  1  vsync_in delayed by 2 cycles
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant (combinational)
- wr_addr  in  ADDR_W  writer address
- wr_data  in  3  writer colour
- clear_req  in  1  single-cycle pulse; starts a full-frame fill
- clear_color  in  3  fill colour, sampled on the accepted clear_req
- clear_busy  out  1  fill in progress
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  3  RAM write data
- ram_rdata  in  3  RAM read data; synchronous read, valid 1 cycle after the address

Behaviour:
Reset values:
- rgb=0, hsync=0, vsync=0.
- Sync delay and read pipeline registers =0.
- clear_busy=0, FSM=IDLE, clear address=0.
- ram_we=0 while rst is asserted.

Display read slot (combinational, cycle t):
- disp_rd = video_on & (pixel_x[SCALE_SHIFT-1:0]==0) & (pixel_x>>S < FB_W) & (pixel_y>>S < FB_H).
- Read address = (pixel_y>>S)*FB_W + (pixel_x>>S), truncated to ADDR_W.
- in_fb = same test without the low-bit condition.

Port priority each cycle:
- 1. Display read.
- 2. Clear write.
- 3. External writer.
- The port carries exactly one access per cycle.
- ram_we=0 on display-read cycles.

Output pipeline (latency 2):
- Register vo_d1, in_fb_d1 and rd_d1 at the end of cycle t.
- At the end of cycle t+1:
  - vo_d1=0 gives rgb<=0.
  - in_fb_d1=0 gives rgb<=BORDER_RGB.
  - rd_d1=1 gives rgb<=ram_rdata.
  - Otherwise rgb holds its value (horizontal replication).
- hsync and vsync pass through two flops, matching the rgb latency.
- Vertical replication is implicit: every screen row re-reads its fb row.

Clear FSM:
- States: IDLE, CLEAR.
- IDLE -> CLEAR on clear_req: latch clear_color, clr_addr<=0, clear_busy<=1.
- In CLEAR, each non-display cycle writes clear_color to clr_addr and increments clr_addr.
- After writing address FB_W*FB_H-1: go to IDLE, clear_busy<=0 on the next edge.
- clear_req while in CLEAR is ignored, with no restart.
- rst asserted mid-clear returns the FSM to IDLE immediately; the fb is left partially filled.

Writer handshake:
- wr_ready = !disp_rd & !clear_busy & !rst.
- The transfer occurs when wr_valid & wr_ready are both high in the same cycle.
- wr_valid must hold and its data stay stable until the transfer.
- wr_addr >= FB_W*FB_H: the transfer is accepted (handshake completes) but dropped, so ram_we=0.
- A writer access gets no RAM read and has no effect on rgb.

Widths:
- Address multiply/add is done at ADDR_W+SCALE_SHIFT bits before truncation.
- pixel_x/pixel_y comparisons are unsigned.

Optional Feature:
- Macro: FBARB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt[15:0]: counts cycles with wr_valid & !wr_ready.
  - The count saturates at 16'hFFFF.
  - It is cleared by rst and by each accepted clear_req.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-frame -> rgb=0, hsync=vsync=0, clear_busy=0, wr_ready=0 during rst.
- Preload fb[0]=3'b101, fb[1]=3'b010. Drive x=0..7, y=0, video_on=1 -> rgb = 101 for 4 cycles then 010 for 4 cycles, first valid 2 cycles after x=0. hsync/vsync follow with the same 2-cycle delay.
- video_on=1 at x=640 (fb width 160*4 exceeded) -> rgb=BORDER_RGB. video_on=0 -> rgb=0.
- wr_valid held at addr 5, data 3'b111, during active video -> wr_ready low on x%4==0 cycles, high otherwise. Exactly one RAM write is seen, and a later readback gives 111.
- wr_addr=19200 with valid -> handshake completes, ram_we stays 0.
- clear_req with colour 3'b011 -> clear_busy high; 19200 writes complete (extra cycles = display slots); then busy drops and every fb word reads 011. A second clear_req mid-clear is ignored. rst mid-clear -> busy 0 next cycle.
